// File: rtl/div_pkg.sv
// Shared types and constants for the divider arbiter: FSM state encoding,
// default operand width and the all-ones result used for error responses.
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } div_state_t;

    localparam int DIV_SIZE_DEFAULT = 64;
    localparam int DIV_MAX_SIZE     = 256;

    // Error result; the top slices this down to its own SIZE.
    localparam logic [DIV_MAX_SIZE-1:0] DIV_ERR_ONES = '1;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: returns a one-hot grant for the first
// asserted request at or after i_ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant
);

    logic [PW:0]   w_sum;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = '0;
        w_idx   = '0;
        for (int off = 0; off < NREQ; off++) begin
            w_sum = {1'b0, i_ptr} + (PW+1)'(off);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            w_idx = w_sum[PW-1:0];
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider among NREQ requesters, one operation
// in flight. Optional watchdog/abort enabled by defining DIV_ARB_TIMEOUT_EN.
module div_arbiter
    import div_pkg::*;
#(
    parameter int SIZE    = DIV_SIZE_DEFAULT,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ*SIZE-1:0] req_dividend_tdata,
    input  logic [NREQ*SIZE-1:0] req_divisor_tdata,
    input  logic [NREQ-1:0]      req_tvalid,
    output logic [NREQ-1:0]      req_tready,
    output logic [SIZE-1:0]      resp_tdata,
    output logic [NREQ-1:0]      resp_tvalid,
    input  logic [NREQ-1:0]      resp_tready,
    output logic [SIZE-1:0]      div_dividend_tdata,
    output logic [SIZE-1:0]      div_divisor_tdata,
    output logic                 div_in_tvalid,
    input  logic                 div_in_tready,
    input  logic [SIZE-1:0]      div_out_tdata,
    input  logic                 div_out_tvalid,
    output logic                 div_out_tready
`ifdef DIV_ARB_TIMEOUT_EN
    ,
    output logic                 div_abort
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam logic [SIZE-1:0] ERR_RESULT = DIV_ERR_ONES[SIZE-1:0];

    if (NREQ < 2 || NREQ > 8 || SIZE < 1 || SIZE > DIV_MAX_SIZE || TIMEOUT < 2) begin : g_param_check
        $error("div_arbiter: parameter out of range");
    end

    div_state_t      r_state, w_state_nxt;
    logic [PW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [PW-1:0]   r_grant, w_grant_nxt;
    logic [NREQ-1:0] r_req_tready, w_req_tready_nxt;
    logic [NREQ-1:0] r_resp_tvalid, w_resp_tvalid_nxt;
    logic [SIZE-1:0] r_resp_tdata, w_resp_tdata_nxt;
    logic            r_div_in_tvalid, w_div_in_tvalid_nxt;
    logic            r_div_out_tready, w_div_out_tready_nxt;
    logic [SIZE-1:0] r_dividend, r_divisor;

    logic [NREQ-1:0] w_grant_oh;
    logic [NREQ-1:0] w_resp_oh;
    logic [PW-1:0]   w_grant_idx;
    logic [PW-1:0]   w_ptr_after;
    logic [SIZE-1:0] w_sel_dividend, w_sel_divisor;
    logic            w_load_ops;

`ifdef DIV_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_div_abort, w_div_abort_nxt;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr (
        .i_req   (req_tvalid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_grant_oh)
    );

    // Grant index and the operands of the winning port.
    always_comb begin
        w_grant_idx    = '0;
        w_sel_dividend = '0;
        w_sel_divisor  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant_oh[i]) begin
                w_grant_idx    = PW'(i);
                w_sel_dividend = req_dividend_tdata[i*SIZE +: SIZE];
                w_sel_divisor  = req_divisor_tdata[i*SIZE +: SIZE];
            end
        end
        w_ptr_after = (w_grant_idx == PW'(NREQ-1)) ? '0 : w_grant_idx + 1'b1;
        w_resp_oh   = NREQ'(1) << r_grant;
    end

    always_comb begin
        w_state_nxt          = r_state;
        w_rr_ptr_nxt         = r_rr_ptr;
        w_grant_nxt          = r_grant;
        w_req_tready_nxt     = '0;
        w_resp_tvalid_nxt    = r_resp_tvalid;
        w_resp_tdata_nxt     = r_resp_tdata;
        w_div_in_tvalid_nxt  = r_div_in_tvalid;
        w_div_out_tready_nxt = r_div_out_tready;
        w_load_ops           = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
        w_cnt_nxt            = r_cnt;
        w_div_abort_nxt      = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (|req_tvalid) begin
                    w_state_nxt         = ST_ISSUE;
                    w_grant_nxt         = w_grant_idx;
                    w_rr_ptr_nxt        = w_ptr_after;
                    w_req_tready_nxt    = w_grant_oh;
                    w_load_ops          = 1'b1;
                    // A zero divisor never raises div_in_tvalid.
                    w_div_in_tvalid_nxt = (w_sel_divisor != '0);
                end
            end
            ST_ISSUE: begin
                if (r_divisor == '0) begin
                    w_state_nxt       = ST_RESP;
                    w_resp_tdata_nxt  = ERR_RESULT;
                    w_resp_tvalid_nxt = w_resp_oh;
                end else if (r_div_in_tvalid && div_in_tready) begin
                    w_state_nxt          = ST_WAIT;
                    w_div_in_tvalid_nxt  = 1'b0;
                    w_div_out_tready_nxt = 1'b1;
`ifdef DIV_ARB_TIMEOUT_EN
                    w_cnt_nxt            = '0;
`endif
                end
            end
            ST_WAIT: begin
                if (r_div_out_tready && div_out_tvalid) begin
                    w_state_nxt          = ST_RESP;
                    w_resp_tdata_nxt     = div_out_tdata;
                    w_resp_tvalid_nxt    = w_resp_oh;
                    w_div_out_tready_nxt = 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
                end else if (r_div_abort) begin
                    w_state_nxt       = ST_RESP;
                    w_resp_tdata_nxt  = ERR_RESULT;
                    w_resp_tvalid_nxt = w_resp_oh;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                    // Abort lands on the TIMEOUT-th WAIT cycle; stop accepting results then.
                    if (r_cnt == CNT_W'(TIMEOUT-2)) begin
                        w_div_abort_nxt      = 1'b1;
                        w_div_out_tready_nxt = 1'b0;
                    end
`endif
                end
            end
            ST_RESP: begin
                if (resp_tready[r_grant]) begin
                    w_state_nxt       = ST_IDLE;
                    w_resp_tvalid_nxt = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_rr_ptr         <= '0;
            r_grant          <= '0;
            r_req_tready     <= '0;
            r_resp_tvalid    <= '0;
            r_resp_tdata     <= '0;
            r_div_in_tvalid  <= 1'b0;
            r_div_out_tready <= 1'b0;
`ifdef DIV_ARB_TIMEOUT_EN
            r_cnt            <= '0;
            r_div_abort      <= 1'b0;
`endif
        end else begin
            r_state          <= w_state_nxt;
            r_rr_ptr         <= w_rr_ptr_nxt;
            r_grant          <= w_grant_nxt;
            r_req_tready     <= w_req_tready_nxt;
            r_resp_tvalid    <= w_resp_tvalid_nxt;
            r_resp_tdata     <= w_resp_tdata_nxt;
            r_div_in_tvalid  <= w_div_in_tvalid_nxt;
            r_div_out_tready <= w_div_out_tready_nxt;
`ifdef DIV_ARB_TIMEOUT_EN
            r_cnt            <= w_cnt_nxt;
            r_div_abort      <= w_div_abort_nxt;
`endif
        end
    end

    // Operand registers are data only and carry no reset.
    always_ff @(posedge clk) begin
        if (w_load_ops) begin
            r_dividend <= w_sel_dividend;
            r_divisor  <= w_sel_divisor;
        end
    end

    assign req_tready         = r_req_tready;
    assign resp_tvalid        = r_resp_tvalid;
    assign resp_tdata         = r_resp_tdata;
    assign div_dividend_tdata = r_dividend;
    assign div_divisor_tdata  = r_divisor;
    assign div_in_tvalid      = r_div_in_tvalid;
    assign div_out_tready     = r_div_out_tready;
`ifdef DIV_ARB_TIMEOUT_EN
    assign div_abort          = r_div_abort;
`endif

endmodule
